// File: rtl/pipeline_ctrl.sv
//==============================================================================
// Module      : pipeline_ctrl
// Description : Hazard / stall / flush / halt-drain control for a 5-stage pipe.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipeline_ctrl #(
   parameter int DRAIN_CYCLES = 3
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [4:0]  rs_id,
   input  logic [4:0]  rt_id,
   input  logic        uses_rt_id,
   input  logic [4:0]  rd_ex,
   input  logic        RWrEn_ex,
   input  logic        MemToReg_ex,
   input  logic        redirect_mem,
   input  logic        halt_id,
   input  logic        dmem_busy,
   output logic        PC_WEN,
   output logic        IFID_WEN,
   output logic        IDEX_WEN,
   output logic        EXMEM_WEN,
   output logic        MEMWB_WEN,
   output logic        IFID_flush,
   output logic        IDEX_flush,
   output logic        EXMEM_flush,
   output logic        halted,
   output logic [15:0] stall_count
);

   localparam int c_CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_DRAIN_INIT = c_CNT_W'(DRAIN_CYCLES);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MEMWAIT = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_HALTED  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               r_ret;
   logic [c_CNT_W-1:0]   r_drain_cnt;
   logic                 r_halted;
   logic [15:0]          r_stall_cnt;

   state_t               w_mode;
   state_t               w_next;
   state_t               w_next_ret;
   logic [c_CNT_W-1:0]   w_next_cnt;
   logic [4:0]           w_wen;     // {PC, IFID, IDEX, EXMEM, MEMWB}
   logic [2:0]           w_flush;   // {IFID, IDEX, EXMEM}
   logic                 w_load_use;
   logic                 w_stall_inc;

   assign w_load_use = MemToReg_ex & RWrEn_ex & (rd_ex != 5'd0) &
                       ((rd_ex == rs_id) | (uses_rt_id & (rd_ex == rt_id)));

   // Once memory completes, MEMWAIT behaves exactly like the state it interrupted.
   assign w_mode = (r_state == ST_MEMWAIT) ? r_ret : r_state;

   always_comb begin
      w_wen      = 5'b00000;
      w_flush    = 3'b000;
      w_next     = r_state;
      w_next_ret = r_ret;
      w_next_cnt = r_drain_cnt;
      if (r_state == ST_HALTED) begin
         w_wen = 5'b11111;
      end else if (dmem_busy) begin
         w_wen  = 5'b11111;
         w_next = ST_MEMWAIT;
         if (r_state != ST_MEMWAIT)
            w_next_ret = r_state;
      end else if (redirect_mem) begin
         // A halt being drained is on the wrong path; resume normal fetch.
         w_flush    = 3'b111;
         w_next     = ST_RUN;
         w_next_ret = ST_RUN;
         w_next_cnt = '0;
      end else if (w_mode == ST_DRAIN) begin
         w_wen   = 5'b11000;
         w_flush = 3'b010;
         if (r_drain_cnt <= c_CNT_ONE) begin
            w_next     = ST_HALTED;
            w_next_cnt = '0;
         end else begin
            w_next     = ST_DRAIN;
            w_next_cnt = r_drain_cnt - c_CNT_ONE;
         end
      end else if (w_load_use) begin
         w_wen   = 5'b11000;
         w_flush = 3'b010;
         w_next  = ST_RUN;
      end else if (halt_id) begin
         w_next     = ST_DRAIN;
         w_next_cnt = c_DRAIN_INIT;
      end else begin
         w_next = ST_RUN;
      end
   end

   assign w_stall_inc = w_wen[4] & ((r_state == ST_RUN) | (r_state == ST_MEMWAIT));

   always_ff @(negedge CLK or negedge RST) begin
      if (!RST) begin
         r_state     <= ST_RUN;
         r_ret       <= ST_RUN;
         r_drain_cnt <= '0;
         r_halted    <= 1'b0;
         r_stall_cnt <= 16'd0;
      end else begin
         r_state     <= w_next;
         r_ret       <= w_next_ret;
         r_drain_cnt <= w_next_cnt;
         r_halted    <= (w_next == ST_HALTED);
         if (w_stall_inc && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   // Reset forces every stage register to load with no bubbles.
   assign PC_WEN      = RST & w_wen[4];
   assign IFID_WEN    = RST & w_wen[3];
   assign IDEX_WEN    = RST & w_wen[2];
   assign EXMEM_WEN   = RST & w_wen[1];
   assign MEMWB_WEN   = RST & w_wen[0];
   assign IFID_flush  = RST & w_flush[2];
   assign IDEX_flush  = RST & w_flush[1];
   assign EXMEM_flush = RST & w_flush[0];
   assign halted      = r_halted;
   assign stall_count = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
//==============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl (vector table + sequences).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipeline_ctrl;

   logic        CLK;
   logic        RST;
   logic [4:0]  rs_id, rt_id, rd_ex;
   logic        uses_rt_id, RWrEn_ex, MemToReg_ex, redirect_mem, halt_id, dmem_busy;
   logic        PC_WEN, IFID_WEN, IDEX_WEN, EXMEM_WEN, MEMWB_WEN;
   logic        IFID_flush, IDEX_flush, EXMEM_flush;
   logic        halted;
   logic [15:0] stall_count;

   int n_chk = 0;
   int n_err = 0;

   pipeline_ctrl #(.DRAIN_CYCLES(3)) dut (
      .CLK(CLK), .RST(RST),
      .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id), .rd_ex(rd_ex),
      .RWrEn_ex(RWrEn_ex), .MemToReg_ex(MemToReg_ex), .redirect_mem(redirect_mem),
      .halt_id(halt_id), .dmem_busy(dmem_busy),
      .PC_WEN(PC_WEN), .IFID_WEN(IFID_WEN), .IDEX_WEN(IDEX_WEN),
      .EXMEM_WEN(EXMEM_WEN), .MEMWB_WEN(MEMWB_WEN),
      .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .EXMEM_flush(EXMEM_flush),
      .halted(halted), .stall_count(stall_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [4:0]  rs, rt;
      logic        urt;
      logic [4:0]  rd;
      logic        rwr, m2r, redir, halt, busy;
      logic [4:0]  wen;
      logic [2:0]  fl;
      logic        hlt;
      logic [15:0] sc;
      logic        sc_chk;
   } vec_t;

   vec_t exp_q[$];

   function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                               input logic [4:0] rd, input logic rwr, input logic m2r,
                               input logic redir, input logic halt, input logic busy,
                               input logic [4:0] wen, input logic [2:0] fl, input logic hlt,
                               input logic [15:0] sc, input logic sc_chk);
      vec_t v;
      v.rs = rs; v.rt = rt; v.urt = urt; v.rd = rd; v.rwr = rwr; v.m2r = m2r;
      v.redir = redir; v.halt = halt; v.busy = busy;
      v.wen = wen; v.fl = fl; v.hlt = hlt; v.sc = sc; v.sc_chk = sc_chk;
      return v;
   endfunction

   // Common stimulus shapes: idle, load-use on rs (r5), halt, redirect, busy.
   function automatic vec_t idle(input logic [4:0] wen, input logic [2:0] fl,
                                 input logic hlt, input logic [15:0] sc, input logic sc_chk);
      return mk(5'd1, 5'd2, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, wen, fl, hlt, sc, sc_chk);
   endfunction

   function automatic vec_t lu(input logic redir, input logic halt, input logic busy,
                               input logic [4:0] wen, input logic [2:0] fl,
                               input logic [15:0] sc);
      return mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, redir, halt, busy, wen, fl, 1'b0, sc, 1'b1);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rs_id = v.rs; rt_id = v.rt; uses_rt_id = v.urt; rd_ex = v.rd;
      RWrEn_ex = v.rwr; MemToReg_ex = v.m2r; redirect_mem = v.redir;
      halt_id = v.halt; dmem_busy = v.busy;
   endtask

   task automatic compare(input string nm, input vec_t e);
      chk({nm, ".wen"}, {27'd0, PC_WEN, IFID_WEN, IDEX_WEN, EXMEM_WEN, MEMWB_WEN}, {27'd0, e.wen});
      chk({nm, ".flush"}, {29'd0, IFID_flush, IDEX_flush, EXMEM_flush}, {29'd0, e.fl});
      chk({nm, ".halted"}, {31'd0, halted}, {31'd0, e.hlt});
      if (e.sc_chk)
         chk({nm, ".stall_count"}, {16'd0, stall_count}, {16'd0, e.sc});
   endtask

   // Drive after the falling (active) edge, sample on the rising edge.
   task automatic apply(input string nm, input vec_t v);
      vec_t e;
      @(negedge CLK); #1;
      drive(v);
      exp_q.push_back(v);
      @(posedge CLK);
      e = exp_q.pop_front();
      compare(nm, e);
   endtask

   task automatic do_reset();
      @(posedge CLK);
      drive(idle(5'b0, 3'b0, 1'b0, 16'd0, 1'b0));
      RST = 1'b0;
      #1;
      chk("rst.wen", {27'd0, PC_WEN, IFID_WEN, IDEX_WEN, EXMEM_WEN, MEMWB_WEN}, 32'd0);
      chk("rst.stall_count", {16'd0, stall_count}, 32'd0);
      chk("rst.halted", {31'd0, halted}, 32'd0);
      repeat (2) @(posedge CLK);
      RST = 1'b1;
   endtask

   vec_t tbl[13];

   initial begin
      RST = 1'b1;
      drive(idle(5'b0, 3'b0, 1'b0, 16'd0, 1'b0));

      tbl[0]  = idle(5'b00000, 3'b000, 1'b0, 16'd0, 1'b1);
      tbl[1]  = lu(1'b0, 1'b0, 1'b0, 5'b11000, 3'b010, 16'd0);
      tbl[2]  = idle(5'b00000, 3'b000, 1'b0, 16'd1, 1'b1);
      tbl[3]  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0, 16'd1, 1'b1);
      tbl[4]  = mk(5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000, 3'b010, 1'b0, 16'd1, 1'b1);
      tbl[5]  = mk(5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0, 16'd2, 1'b1);
      tbl[6]  = mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0, 16'd2, 1'b1);
      tbl[7]  = mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0, 16'd2, 1'b1);
      tbl[8]  = lu(1'b1, 1'b0, 1'b0, 5'b00000, 3'b111, 16'd2);
      tbl[9]  = lu(1'b0, 1'b1, 1'b0, 5'b11000, 3'b010, 16'd2);
      tbl[10] = idle(5'b00000, 3'b000, 1'b0, 16'd3, 1'b1);
      tbl[11] = mk(5'd1, 5'd2, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, 3'b111, 1'b0, 16'd3, 1'b1);
      tbl[12] = idle(5'b00000, 3'b000, 1'b0, 16'd3, 1'b1);

      do_reset();
      for (int i = 0; i < 13; i++)
         apply($sformatf("tbl%0d", i), tbl[i]);

      // dmem_busy for 4 cycles over a load-use, then the stall itself.
      do_reset();
      for (int i = 0; i < 4; i++)
         apply($sformatf("busy%0d", i), lu(1'b0, 1'b0, 1'b1, 5'b11111, 3'b000, 16'(i)));
      apply("busy_rel", lu(1'b0, 1'b0, 1'b0, 5'b11000, 3'b010, 16'd4));
      apply("busy_end", idle(5'b00000, 3'b000, 1'b0, 16'd5, 1'b1));

      // Halt drains for 3 cycles, then HALTED ignores redirects.
      do_reset();
      apply("halt0", mk(5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 3'b000, 1'b0, 16'd0, 1'b1));
      for (int i = 1; i <= 3; i++)
         apply($sformatf("drain%0d", i), idle(5'b11000, 3'b010, 1'b0, 16'd0, 1'b1));
      apply("halted", idle(5'b11111, 3'b000, 1'b1, 16'd0, 1'b1));
      apply("halted_redir", mk(5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11111, 3'b000, 1'b1, 16'd0, 1'b1));

      // Halt with two busy cycles inside the drain: halted after 5 cycles.
      do_reset();
      apply("hb0", mk(5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 3'b000, 1'b0, 16'd0, 1'b1));
      apply("hb1", mk(5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11111, 3'b000, 1'b0, 16'd0, 1'b0));
      apply("hb2", mk(5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11111, 3'b000, 1'b0, 16'd0, 1'b0));
      for (int i = 3; i <= 5; i++)
         apply($sformatf("hb%0d", i), idle(5'b11000, 3'b010, 1'b0, 16'd0, 1'b0));
      apply("hb6", idle(5'b11111, 3'b000, 1'b1, 16'd0, 1'b0));

      // Redirect on the first drain cycle cancels the halt.
      do_reset();
      apply("rd0", mk(5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 3'b000, 1'b0, 16'd0, 1'b1));
      apply("rd1", mk(5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, 3'b111, 1'b0, 16'd0, 1'b1));
      for (int i = 2; i <= 5; i++)
         apply($sformatf("rd%0d", i), idle(5'b00000, 3'b000, 1'b0, 16'd0, 1'b1));

      // Asynchronous reset in the middle of MEMWAIT.
      do_reset();
      apply("mw0", lu(1'b0, 1'b0, 1'b1, 5'b11111, 3'b000, 16'd0));
      apply("mw1", lu(1'b0, 1'b0, 1'b1, 5'b11111, 3'b000, 16'd1));
      #2 RST = 1'b0;
      #1;
      chk("mwrst.wen", {27'd0, PC_WEN, IFID_WEN, IDEX_WEN, EXMEM_WEN, MEMWB_WEN}, 32'd0);
      chk("mwrst.flush", {29'd0, IFID_flush, IDEX_flush, EXMEM_flush}, 32'd0);
      chk("mwrst.stall_count", {16'd0, stall_count}, 32'd0);
      chk("mwrst.halted", {31'd0, halted}, 32'd0);
      @(posedge CLK);
      drive(idle(5'b0, 3'b0, 1'b0, 16'd0, 1'b0));
      RST = 1'b1;
      apply("mw_lu", lu(1'b0, 1'b0, 1'b0, 5'b11000, 3'b010, 16'd0));
      apply("mw_idle", idle(5'b00000, 3'b000, 1'b0, 16'd1, 1'b1));

      // Saturation: climb to 0xFFFE, then keep stalling.
      do_reset();
      @(negedge CLK); #1;
      drive(lu(1'b0, 1'b0, 1'b0, 5'b11000, 3'b010, 16'd0));
      repeat (65533) @(negedge CLK);
      apply("sat0", lu(1'b0, 1'b0, 1'b0, 5'b11000, 3'b010, 16'hFFFE));
      apply("sat1", lu(1'b0, 1'b0, 1'b0, 5'b11000, 3'b010, 16'hFFFF));
      apply("sat2", lu(1'b0, 1'b0, 1'b0, 5'b11000, 3'b010, 16'hFFFF));
      apply("sat3", idle(5'b00000, 3'b000, 1'b0, 16'hFFFF, 1'b1));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
